oam_dma: RTL and testbench
==========================

# oam_dma

Sprite-attribute DMA engine for the DMG bus. A one-cycle start pulse carrying a source page (the value the CPU writes to FF46) copies 160 bytes from `{page, 8'h00}`–`{page, 8'h9F}` into OAM. The block is a read master on the main single-port synchronous RAM (registered `q`, one-cycle read latency, `q` holds while `ren` is low) and the sole write master on the OAM RAM instance. It sits directly upstream of both memory instances, behind the bus arbiter's grant.

## Interface
Parameters:
- `p_ADDR_BITS`, 16, source address width
- `p_DATA_BITS`, 8, data width
- `p_OAM_LEN`, 160, bytes per transfer; must be ≤ 256
- `p_OAM_ADDR_BITS`, 8, OAM index width

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; `src_page` is valid with it
- `src_page`  in  8  source high byte
- `mem_gnt`  in  1  arbiter grant for the main RAM port
- `mem_ren`  out  1  main RAM read enable
- `mem_addr`  out  p_ADDR_BITS  `{src_page_q, rd_idx}`
- `mem_q`  in  p_DATA_BITS  main RAM read data
- `oam_wen`  out  1  OAM write enable
- `oam_addr`  out  p_OAM_ADDR_BITS  OAM byte index
- `oam_data`  out  p_DATA_BITS  equals `mem_q` (combinational passthrough)
- `busy`  out  1  high from SETUP to the final OAM write, inclusive
- `done`  out  1  one-cycle pulse after a completed transfer

## Operation
- States: IDLE, SETUP, XFER.
  - IDLE → SETUP on `start`.
  - SETUP → XFER unconditionally after one cycle. This models the hardware start-up delay.
  - XFER → IDLE after the write of index `p_OAM_LEN-1`.
- On `start`: latch `src_page_q`, clear `rd_idx`, clear `rd_pend`.
- `mem_ren = (state==XFER) && (rd_idx < p_OAM_LEN) && mem_gnt`. This is combinational. `mem_addr` is also driven in non-XFER states, with `mem_ren` low.
- A read is issued at an edge where `mem_ren` is high. At that edge: `rd_idx++`, `rd_pend` is set, and `oam_addr_q` takes the old `rd_idx`.
- `oam_wen` = `rd_pend` (registered). OAM samples `mem_q` at the next edge.
- `rd_idx` is 9 bits wide, which gives no wrap at 256. The read address low byte never exceeds `p_OAM_LEN-1`.
- While `mem_gnt` is low, no read is issued and `rd_idx` holds. A pending write still completes, because `mem_q` is held by the RAM.
- `start` while SETUP or XFER restarts the transfer:
  - New page is latched, `rd_idx` is set to 0, and state goes to SETUP.
  - A read issued in that same cycle gets no write (`rd_pend` is cleared).
  - An `oam_wen` already asserted in that cycle still commits.
  - `done` is not pulsed for the aborted transfer.
- A `start` in the same cycle as the final write also restarts; no `done` is pulsed.
- `src_page` is used as-is, including `8'hE0`–`8'hFF`. Address decoding is the bus's job.
- Reset mid-transfer: everything returns to IDLE, no `done`, and OAM is left partially written.
- Reset values:
  - state IDLE; `rd_idx` 0; `rd_pend` 0; `src_page_q` 8'h00
  - `mem_ren` 0, `mem_addr` 16'h0000
  - `oam_wen` 0, `oam_addr` 0
  - `busy` 0, `done` 0

## Timing
All of the following assume `mem_gnt` held high, with `start` sampled at the end of cycle 0:
- Cycle 1: SETUP, `busy`=1, `mem_ren`=0.
- Cycles 2..161: `mem_ren`=1, `mem_addr` = `{page, i}` with i = cycle−2.
- Cycles 3..162: `oam_wen`=1, `oam_addr` = cycle−3, `oam_data` = byte i.
- Cycle 163: IDLE, `busy`=0, `done`=1. Total `busy` time is 162 cycles.

Each low-grant cycle during XFER adds exactly one cycle to the transfer. `busy` and `done` are registered; `mem_ren` and `mem_addr` are combinational from registered state.

## Structure
- Package `dmg_dma_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SETUP, XFER} dma_state_t`
  - `OAM_LEN = 160`
  - `OAM_BASE = 16'hFE00` and `DMA_REG_ADDR = 16'hFF46` (used by the bus decoder)
- Single flat module; no sub-module.
- The OAM RAM is instantiated by the parent using the existing synchronous RAM with `p_ADDR_BITS=8` and `p_MEM_ROW_NUM=160`.

## Test plan
- **Basic copy:** main RAM `C000+i` = `i^8'h5A`; `start` with `src_page`=8'hC0 → OAM[i] = `i^8'h5A` for i=0..159. `done` is high only in cycle 163; `busy` is high for 162 cycles.
- **Grant stalls:** `mem_gnt` low every 3rd cycle during XFER → OAM contents identical to the basic copy, with no duplicated or skipped indices.
- **Restart:** second `start` with page 8'hD0 in cycle 50 → OAM ends with the D0xx data, only one `done` pulse, and no write of the read issued in cycle 50.
- **Reset mid-transfer:** `rst_n` low at cycle 80 → all outputs 0 immediately (asynchronous); OAM[0..77] written, OAM[78..159] unchanged; no `done`.
- **Boundary page:** `src_page`=8'hFF → `mem_addr` spans FF00..FF9F exactly; `rd_idx` never exceeds 159.
- **Back-to-back:** `start` in the cycle `done` is high → new transfer begins cleanly, `busy` goes high next cycle, and both transfers are complete.

Source files
------------

// File: rtl/dmg_dma_pkg.sv
// -----------------------------------------------------------------------------
// dmg_dma_pkg
//
// Shared definitions for the sprite-attribute (OAM) DMA engine and the bus
// logic around it.
//
//   dma_state_t   : engine state encoding (IDLE / SETUP / XFER)
//   OAM_LEN       : bytes copied per transfer (one full OAM image)
//   OAM_BASE      : CPU-visible base address of OAM (bus decoder)
//   DMA_REG_ADDR  : address of the DMA start register, FF46 (bus decoder)
// -----------------------------------------------------------------------------
package dmg_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam int          OAM_LEN      = 160;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//
// Copies p_OAM_LEN bytes from {page, 8'h00} upward in main RAM into OAM after
// a one-cycle start pulse. The engine is a read master on the main RAM
// (registered q, one-cycle latency, q held while ren is low) and the only
// write master on the OAM RAM. Read data is forwarded to OAM unregistered;
// the write for a read is issued in the cycle after that read.
//
// Ports
//   clk       in   clock, all state changes on posedge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request; src_page valid with it. A start while a
//                  transfer is running restarts it with the new page.
//   src_page  in   source high byte (value written to FF46), used unfiltered
//   mem_gnt   in   arbiter grant for the main RAM port; no read without it
//   mem_ren   out  main RAM read enable (combinational from state)
//   mem_addr  out  {src_page_q, rd_idx} (combinational from state)
//   mem_q     in   main RAM read data
//   oam_wen   out  OAM write enable (registered)
//   oam_addr  out  OAM byte index (registered)
//   oam_data  out  mem_q passed straight through
//   busy      out  high from SETUP through the cycle of the last OAM write
//   done      out  one-cycle pulse after a transfer completes (not on abort)
//
// Handshake: a main RAM read is issued on any rising edge where mem_ren is
// high; mem_ren already includes mem_gnt, so there is no separate ready.
// The matching OAM write is presented in the following cycle with oam_wen
// high and is accepted by the OAM RAM unconditionally at the next edge.
//
// p_OAM_LEN must be <= 256 so the read address low byte stays in one page.
// -----------------------------------------------------------------------------
module oam_dma
    import dmg_dma_pkg::*;
#(
    parameter int p_ADDR_BITS     = 16,
    parameter int p_DATA_BITS     = 8,
    parameter int p_OAM_LEN       = OAM_LEN,
    parameter int p_OAM_ADDR_BITS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 src_page,
    input  logic                       mem_gnt,
    output logic                       mem_ren,
    output logic [p_ADDR_BITS-1:0]     mem_addr,
    input  logic [p_DATA_BITS-1:0]     mem_q,
    output logic                       oam_wen,
    output logic [p_OAM_ADDR_BITS-1:0] oam_addr,
    output logic [p_DATA_BITS-1:0]     oam_data,
    output logic                       busy,
    output logic                       done
);

    // Nine bits so that the "all reads issued" value (p_OAM_LEN, up to 256)
    // is representable without wrapping back to 0.
    localparam int                  IDX_BITS = 9;
    localparam logic [IDX_BITS-1:0] LEN_IDX  = IDX_BITS'(p_OAM_LEN);

    dma_state_t                 state_q,    state_d;
    logic [IDX_BITS-1:0]        rd_idx_q,   rd_idx_d;
    logic                       rd_pend_q,  rd_pend_d;
    logic [7:0]                 src_page_q, src_page_d;
    logic [p_OAM_ADDR_BITS-1:0] oam_addr_q, oam_addr_d;
    logic                       busy_q,     busy_d;
    logic                       done_q,     done_d;

    logic rd_fire;   // a main RAM read is issued at the coming edge
    logic last_wr;   // this cycle carries the write of the final byte

    assign rd_fire = (state_q == XFER) && (rd_idx_q < LEN_IDX) && mem_gnt;

    // A pending write always belongs to index rd_idx_q-1, so the final write
    // is the pending one once every read has been issued.
    assign last_wr = (state_q == XFER) && rd_pend_q && (rd_idx_q == LEN_IDX);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        rd_pend_d  = rd_pend_q;
        src_page_d = src_page_q;
        oam_addr_d = oam_addr_q;
        done_d     = 1'b0;

        if (start) begin
            // Start wins over everything, including a read issued this cycle
            // (its data is dropped) and the final write (no done for it).
            // A write already presented this cycle still lands in OAM.
            state_d    = SETUP;
            src_page_d = src_page;
            rd_idx_d   = '0;
            rd_pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_pend_d = 1'b0;
                end
                SETUP: begin
                    // Fixed one-cycle start-up delay before the first read.
                    state_d = XFER;
                end
                XFER: begin
                    rd_pend_d = rd_fire;
                    if (rd_fire) begin
                        rd_idx_d   = rd_idx_q + IDX_BITS'(1);
                        oam_addr_d = p_OAM_ADDR_BITS'(rd_idx_q);
                    end
                    if (last_wr) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rd_pend_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            src_page_q <= 8'h00;
            oam_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            rd_pend_q  <= rd_pend_d;
            src_page_q <= src_page_d;
            oam_addr_q <= oam_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_ren  = rd_fire;
    // Driven in every state; only meaningful while mem_ren is high.
    assign mem_addr = p_ADDR_BITS'({src_page_q, rd_idx_q[7:0]});
    assign oam_wen  = rd_pend_q;
    assign oam_addr = oam_addr_q;
    // The RAM holds q while ren is low, so a write stalled behind a dropped
    // grant still sees the byte it was issued for.
    assign oam_data = mem_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
module tb_oam_dma;
    import dmg_dma_pkg::*;

    localparam int LEN = OAM_LEN;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  src_page;
    logic        mem_gnt;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [7:0]  mem_q = 8'h00;
    logic        oam_wen;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_page (src_page),
        .mem_gnt  (mem_gnt),
        .mem_ren  (mem_ren),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .oam_wen  (oam_wen),
        .oam_addr (oam_addr),
        .oam_data (oam_data),
        .busy     (busy),
        .done     (done)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int t0           = 0;   // cycle in which the latest start was sampled
    int gnt_mode     = 0;   // 0 always granted, 1 low every 3rd cycle, 2 random

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory models and observation logs ----------------
    logic [7:0]  main_mem [0:65535];
    logic [7:0]  oam_mem  [0:LEN-1];
    logic [7:0]  exp_oam  [0:LEN-1];
    logic        ren_s = 1'b0;
    logic [15:0] addr_s = 16'h0000;
    logic [15:0] wr_q[$];     // {index, data} of every OAM write seen
    logic [15:0] addr_q[$];   // address of every main RAM read issued
    int          done_q[$];   // cycle of every done pulse
    bit          busy_hist [0:8191];
    bit          gnt_hist  [0:1023];
    logic [15:0] exp_q[$];    // expected OAM write sequence

    // Synchronous main RAM: q registered, held while ren is low.
    always @(posedge clk) if (ren_s) mem_q <= main_mem[addr_s];

    always @(negedge clk) begin
        ren_s  <= mem_ren;
        addr_s <= mem_addr;
        if (oam_wen) wr_q.push_back({oam_addr, oam_data});
        if (mem_ren) addr_q.push_back(mem_addr);
        if (done)    done_q.push_back(cyc);
        if (cyc < 8192) busy_hist[cyc] <= busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        int rel;
        bit g;
        @(posedge clk);
        #1;
        rel = cyc - t0;
        case (gnt_mode)
            0:       g = 1'b1;
            1:       g = ((rel % 3) != 0);
            default: g = ($urandom_range(0, 3) != 0);
        endcase
        mem_gnt = g;
        if (rel >= 0 && rel < 1024) gnt_hist[rel] = g;
    endtask

    task automatic do_start(input logic [7:0] page);
        t0       = cyc;
        start    = 1'b1;
        src_page = page;
        tick();
        start    = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k = 0;
        while (done_q.size() < target && k < budget) begin
            tick();
            k++;
        end
        check({tag, " done within budget"}, 32'(k < budget), 32'd1);
        tick();
        tick();
    endtask

    // Reference: byte i of the page lands at OAM index i, in index order.
    task automatic expect_copy(input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = main_mem[{page, 8'(i)}];
            exp_q.push_back({8'(i), b});
            exp_oam[i] = b;
        end
    endtask

    task automatic check_writes(input string tag, input int w0);
        int n;
        n = wr_q.size() - w0;
        check({tag, " write count"}, 32'(n), 32'(exp_q.size()));
        for (int k = 0; k < n; k++) begin
            if (k < exp_q.size()) check({tag, " write"}, 32'(wr_q[w0 + k]), 32'(exp_q[k]));
            if (wr_q[w0 + k][15:8] < 8'(LEN)) oam_mem[wr_q[w0 + k][15:8]] = wr_q[w0 + k][7:0];
        end
        exp_q.delete();
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < LEN; i++) check({tag, " oam byte"}, 32'(oam_mem[i]), 32'(exp_oam[i]));
    endtask

    task automatic check_addrs(input string tag, input int base, input logic [7:0] page, input int n);
        for (int i = 0; i < n; i++) check({tag, " read addr"}, 32'(addr_q[base + i]), 32'({page, 8'(i)}));
    endtask

    task automatic check_done(input string tag, input int d0, input int n, input int c1, input int c2);
        check({tag, " done count"}, 32'(done_q.size() - d0), 32'(n));
        if (n >= 1) check({tag, " done cycle 1"}, 32'(done_q[d0]), 32'(c1));
        if (n >= 2) check({tag, " done cycle 2"}, 32'(done_q[d0 + 1]), 32'(c2));
    endtask

    function automatic int count_busy(input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (busy_hist[c]) n++;
        return n;
    endfunction

    // Reads need 160 granted XFER cycles starting at cycle 2 after start.
    function automatic int last_read_cycle();
        int n = 0;
        for (int c = 2; c < 1024; c++) begin
            if (gnt_hist[c]) n++;
            if (n == LEN) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, " mem_ren"},  32'(mem_ren),  32'd0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, " oam_wen"},  32'(oam_wen),  32'd0);
        check({tag, " oam_addr"}, 32'(oam_addr), 32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " done"},     32'(done),     32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0, d0, a0, l, ta;
        logic [7:0] pg;

        rst_n    = 1'b0;
        start    = 1'b0;
        src_page = 8'h00;
        mem_gnt  = 1'b1;
        for (int a = 0; a < 65536; a++) main_mem[a] = 8'($urandom);
        for (int i = 0; i < LEN; i++) main_mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < LEN; i++) begin
            oam_mem[i] = 8'hEE;
            exp_oam[i] = 8'hEE;
        end

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Basic copy, fixed timing.
        gnt_mode = 0;
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(8'hC0);
        wait_done("basic", d0 + 1, 600);
        expect_copy(8'hC0, LEN);
        check_writes("basic", w0);
        check_oam("basic");
        check_done("basic", d0, 1, t0 + 163, 0);
        check("basic busy before", 32'(count_busy(t0, t0)), 32'd0);
        check("basic busy span", 32'(count_busy(t0 + 1, t0 + 162)), 32'd162);
        check("basic busy after", 32'(count_busy(t0 + 163, t0 + 164)), 32'd0);
        check("basic read count", 32'(addr_q.size() - a0), 32'(LEN));
        check_addrs("basic", a0, 8'hC0, LEN);

        // Random grant drops, random page.
        gnt_mode = 2;
        pg = 8'($urandom_range(0, 255));
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(pg);
        wait_done("rand stall", d0 + 1, 900);
        l = last_read_cycle();
        expect_copy(pg, LEN);
        check_writes("rand stall", w0);
        check_oam("rand stall");
        check_done("rand stall", d0, 1, t0 + l + 2, 0);
        check("rand stall busy span", 32'(count_busy(t0 + 1, t0 + l + 1)), 32'(l + 1));
        check("rand stall busy after", 32'(count_busy(t0 + l + 2, t0 + l + 2)), 32'd0);
        check("rand stall read count", 32'(addr_q.size() - a0), 32'(LEN));
        check_addrs("rand stall", a0, pg, LEN);

        // Grant low every third cycle.
        gnt_mode = 1;
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(8'hC0);
        wait_done("stall3", d0 + 1, 900);
        l = last_read_cycle();
        expect_copy(8'hC0, LEN);
        check_writes("stall3", w0);
        check_oam("stall3");
        check_done("stall3", d0, 1, t0 + l + 2, 0);
        check("stall3 busy span", 32'(count_busy(t0 + 1, t0 + l + 1)), 32'(l + 1));
        check("stall3 read count", 32'(addr_q.size() - a0), 32'(LEN));
        check_addrs("stall3", a0, 8'hC0, LEN);

        // Restart with page D0 in cycle 50.
        gnt_mode = 0;
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(8'hC0);
        ta = t0;
        while (cyc - t0 < 50) tick();
        do_start(8'hD0);
        wait_done("restart", d0 + 1, 600);
        expect_copy(8'hC0, 48);
        expect_copy(8'hD0, LEN);
        check_writes("restart", w0);
        check_oam("restart");
        check_done("restart", d0, 1, ta + 50 + 163, 0);
        check("restart busy span", 32'(count_busy(ta + 1, ta + 212)), 32'd212);
        check("restart busy after", 32'(count_busy(ta + 213, ta + 213)), 32'd0);
        check("restart read count", 32'(addr_q.size() - a0), 32'(49 + LEN));
        check_addrs("restart old", a0, 8'hC0, 49);
        check_addrs("restart new", a0 + 49, 8'hD0, LEN);

        // Reset asserted just after the edge ending cycle 80.
        pg = 8'($urandom_range(0, 255));
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(pg);
        ta = t0;
        while (cyc - t0 < 81) tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        expect_copy(pg, 78);
        check_writes("mid reset", w0);
        check_oam("mid reset");
        check_done("mid reset", d0, 0, 0, 0);
        check("mid reset busy span", 32'(count_busy(ta + 1, ta + 80)), 32'd80);
        check("mid reset busy after", 32'(count_busy(ta + 81, ta + 100)), 32'd0);
        check("mid reset read count", 32'(addr_q.size() - a0), 32'd79);
        check_addrs("mid reset", a0, pg, 79);

        // Top page FF: reads FF00..FF9F only.
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(8'hFF);
        wait_done("page ff", d0 + 1, 600);
        expect_copy(8'hFF, LEN);
        check_writes("page ff", w0);
        check_oam("page ff");
        check_done("page ff", d0, 1, t0 + 163, 0);
        check("page ff read count", 32'(addr_q.size() - a0), 32'(LEN));
        check("page ff first addr", 32'(addr_q[a0]), 32'h0000FF00);
        check("page ff last addr", 32'(addr_q[a0 + LEN - 1]), 32'h0000FF9F);
        check_addrs("page ff", a0, 8'hFF, LEN);

        // Back-to-back: new start in the cycle done is high.
        w0 = wr_q.size(); d0 = done_q.size(); a0 = addr_q.size();
        do_start(8'hC0);
        ta = t0;
        while (cyc - t0 < 163) tick();
        check("b2b done at 163", 32'(done), 32'd1);
        do_start(8'hD0);
        check("b2b busy next", 32'(busy), 32'd1);
        wait_done("b2b", d0 + 2, 600);
        expect_copy(8'hC0, LEN);
        expect_copy(8'hD0, LEN);
        check_writes("b2b", w0);
        check_oam("b2b");
        check_done("b2b", d0, 2, ta + 163, ta + 326);
        check("b2b busy first", 32'(count_busy(ta + 1, ta + 162)), 32'd162);
        check("b2b busy gap", 32'(count_busy(ta + 163, ta + 163)), 32'd0);
        check("b2b busy second", 32'(count_busy(ta + 164, ta + 325)), 32'd162);
        check("b2b read count", 32'(addr_q.size() - a0), 32'(2 * LEN));
        check_addrs("b2b second", a0 + LEN, 8'hD0, LEN);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
